// File: rtl/mod3_serial_sched_if.sv
// Requester-side bus of the shared mod-3 residue scheduler.
// The optional abort input exists only when MOD3_SCHED_ABORT_EN is defined.
interface mod3_serial_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [1:0]            residue;
  logic                  divisible;
`ifdef MOD3_SCHED_ABORT_EN
  logic                  abort;
`endif

  modport master (
`ifdef MOD3_SCHED_ABORT_EN
    output abort,
`endif
    output req, data,
    input  gnt, busy, done, done_id, residue, divisible
  );

  modport slave (
`ifdef MOD3_SCHED_ABORT_EN
    input  abort,
`endif
    input  req, data,
    output gnt, busy, done, done_id, residue, divisible
  );
endinterface

// File: rtl/mod3_serial_sched.sv
// Round-robin scheduler feeding one bit-serial divide-by-3 residue FSM shared by NREQ clients.
// Defining MOD3_SCHED_ABORT_EN adds an abort input that cancels the word being shifted.
module mod3_serial_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                clk,
  input  logic                reset,
  mod3_serial_sched_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [NREQ-1:0]  gnt_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       fsm_q, fsm_d;
  logic [1:0]       residue_q;
  logic [IDW-1:0]   done_id_q;
  logic [WIDTH-1:0] shreg_q;

  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [NREQ-1:0]  win_onehot;
  logic [WIDTH-1:0] win_word;
  logic             grant_go, last_bit, abort_go;

  // r' = (2r + b) mod 3; the unused code 2'b11 falls back to R0
  function automatic logic [1:0] res_next(input logic [1:0] r, input logic b);
    case (r)
      R0:      res_next = b ? R1 : R0;
      R1:      res_next = b ? R0 : R2;
      R2:      res_next = b ? R2 : R1;
      default: res_next = R0;
    endcase
  endfunction

  // Winner is the first request above ptr, wrapping to the lowest at or below it
  always_comb begin
    win_vld    = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_word   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!win_vld && bus.req[j] && (IDW'(j) > ptr_q)) begin
        win_vld = 1'b1;
        win_idx = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!win_vld && bus.req[j] && (IDW'(j) <= ptr_q)) begin
        win_vld = 1'b1;
        win_idx = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == win_idx) begin
        win_onehot[j] = 1'b1;
        win_word      = bus.data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign grant_go = win_vld && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign fsm_d    = res_next(fsm_q, shreg_q[WIDTH-1]);
`ifdef MOD3_SCHED_ABORT_EN
  assign abort_go = bus.abort && (state_q == S_SHIFT);
`else
  assign abort_go = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_go) state_d = S_SHIFT;
      S_SHIFT: begin
        if (abort_go)      state_d = S_IDLE;
        else if (last_bit) state_d = S_DONE;
      end
      S_DONE:  state_d = grant_go ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    bus.done      = (state_q == S_DONE);
    bus.done_id   = done_id_q;
    bus.residue   = residue_q;
    bus.divisible = (residue_q == R0);
  end

  // Control and held result registers; the result latches on the last-bit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= IDW'(NREQ - 1);
      gnt_q     <= '0;
      cnt_q     <= '0;
      fsm_q     <= R0;
      residue_q <= R0;
      done_id_q <= '0;
    end else begin
      gnt_q <= '0;
      if (grant_go) begin
        ptr_q <= win_idx;
        gnt_q <= win_onehot;
        cnt_q <= '0;
        fsm_q <= R0;
      end else if ((state_q == S_SHIFT) && !abort_go) begin
        fsm_q <= fsm_d;
        cnt_q <= cnt_q + CW'(1);
        if (last_bit) begin
          residue_q <= fsm_d;
          done_id_q <= ptr_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_go)                  shreg_q <= win_word;
    else if (state_q == S_SHIFT)   shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
  end
endmodule
